// File: rtl/gate_arbiter_if.sv
// Signal bundle between the parking-lane controllers / barrier hardware and gate_arbiter.
// The arbiter side uses the slave modport; the lanes and barrier sensors use master.
interface gate_arbiter_if;
  logic entry_req;
  logic exit_req;
  logic lim_open;
  logic lim_closed;
  logic beam_n;
  logic fault_clr;
  logic entry_gnt;
  logic exit_gnt;
  logic motor_cw;
  logic motor_ccw;
  logic busy;
  logic done;
  logic fault;

  modport master (
    output entry_req, exit_req, lim_open, lim_closed, beam_n, fault_clr,
    input  entry_gnt, exit_gnt, motor_cw, motor_ccw, busy, done, fault
  );

  modport slave (
    input  entry_req, exit_req, lim_open, lim_closed, beam_n, fault_clr,
    output entry_gnt, exit_gnt, motor_cw, motor_ccw, busy, done, fault
  );
endinterface

// File: rtl/gate_arbiter.sv
// Arbiter and open/hold/close sequencer for the barrier shared by entry and exit lanes.
// Define GATE_ARB_RR_EN for round-robin tie breaking; otherwise exit wins every tie.
module gate_arbiter #(
  parameter int unsigned MOVE_TIMEOUT = 50_000_000,
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned CW           = 32
) (
  input logic           clk,
  input logic           reset,
  gate_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StOpening,
    StHold,
    StClosing,
    StFault
  } state_e;

  localparam logic [CW-1:0] MoveLast = CW'(MOVE_TIMEOUT - 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [1:0]    gnt_q, gnt_d;   // {exit, entry}
  logic          motor_cw_q, motor_cw_d;
  logic          motor_ccw_q, motor_ccw_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic [1:0]    pick;
  logic          start_grant;
  logic          conflict;

  assign conflict = bus.lim_open & bus.lim_closed;

`ifdef GATE_ARB_RR_EN
  logic last_exit_q, last_exit_d;

  always_comb begin
    last_exit_d = last_exit_q;
    if (start_grant) begin
      last_exit_d = pick[1];
    end
  end

  // Reset to "exit last served" so the first tie goes to entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_exit_q <= 1'b1;
    end else begin
      last_exit_q <= last_exit_d;
    end
  end
`endif

  always_comb begin
    pick = 2'b00;
    if (bus.entry_req && !bus.exit_req) begin
      pick = 2'b01;
    end else if (bus.exit_req && !bus.entry_req) begin
      pick = 2'b10;
    end else if (bus.entry_req && bus.exit_req) begin
`ifdef GATE_ARB_RR_EN
      pick = last_exit_q ? 2'b01 : 2'b10;
`else
      pick = 2'b10;
`endif
    end
  end

  // State register together with the registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      gnt_q       <= 2'b00;
      motor_cw_q  <= 1'b1;
      motor_ccw_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      motor_cw_q  <= motor_cw_d;
      motor_ccw_q <= motor_ccw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!bus.lim_closed) begin
          state_d = StClosing;  // homing, no owner
        end else if (|pick) begin
          state_d     = StOpening;
          start_grant = 1'b1;
        end
      end
      StOpening: begin
        if (conflict) begin
          state_d = StFault;
        end else if (bus.lim_open) begin
          state_d = StHold;
        end else if (timer_q == MoveLast) begin
          state_d = StFault;
        end
      end
      StHold: begin
        if (conflict) begin
          state_d = StFault;
        end else if (bus.beam_n && timer_q == HoldLast) begin
          state_d = StClosing;
        end
      end
      StClosing: begin
        // Beam outranks the closed limit: a vehicle under the barrier always reverses it.
        if (conflict) begin
          state_d = StFault;
        end else if (!bus.beam_n) begin
          state_d = StOpening;
        end else if (bus.lim_closed) begin
          state_d = StIdle;
        end else if (timer_q == MoveLast) begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (bus.fault_clr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (state_d != state_q || state_q == StIdle || state_q == StFault) begin
      timer_d = '0;
    end else if (state_q == StHold && !bus.beam_n) begin
      timer_d = '0;
    end

    gnt_d = gnt_q;
    if (start_grant) begin
      gnt_d = pick;
    end else if (state_d == StIdle || state_d == StFault) begin
      gnt_d = 2'b00;
    end

    motor_cw_d  = (state_d != StOpening);
    motor_ccw_d = (state_d != StClosing);
    busy_d      = (state_d != StIdle);
    fault_d     = (state_d == StFault);
    done_d      = (state_q == StClosing) && (state_d == StIdle) && (|gnt_q);
  end

  assign bus.entry_gnt = gnt_q[0];
  assign bus.exit_gnt  = gnt_q[1];
  assign bus.motor_cw  = motor_cw_q;
  assign bus.motor_ccw = motor_ccw_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter with MOVE_TIMEOUT=16, HOLD_CYCLES=8.
// Output vector order: {entry_gnt, exit_gnt, motor_cw, motor_ccw, busy, done, fault}.
module tb_gate_arbiter;
  logic clk;
  logic reset;
  int   chk_cnt;
  int   pass_cnt;

  gate_arbiter_if bus ();

  gate_arbiter #(
    .MOVE_TIMEOUT(16),
    .HOLD_CYCLES (8),
    .CW          (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  localparam logic [6:0] IdleV      = 7'b0011000;
  localparam logic [6:0] OpenEntry  = 7'b1001100;
  localparam logic [6:0] OpenExit   = 7'b0101100;
  localparam logic [6:0] HoldEntry  = 7'b1011100;
  localparam logic [6:0] HoldExit   = 7'b0111100;
  localparam logic [6:0] CloseEntry = 7'b1010100;
  localparam logic [6:0] CloseNone  = 7'b0010100;
  localparam logic [6:0] DoneV      = 7'b0011010;
  localparam logic [6:0] FaultV     = 7'b0011101;

`ifdef GATE_ARB_RR_EN
  localparam logic [6:0] TieFirst  = OpenEntry;
  localparam logic [6:0] TieSecond = OpenExit;
`else
  localparam logic [6:0] TieFirst  = OpenExit;
  localparam logic [6:0] TieSecond = OpenExit;
`endif

  logic [6:0] obs;
  assign obs = {bus.entry_gnt, bus.exit_gnt, bus.motor_cw, bus.motor_ccw,
                bus.busy, bus.done, bus.fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the first OPENING cycle: reach HOLD, sit 8 cycles, close onto lim_closed.
  task automatic run_to_idle();
    bus.lim_closed = 1'b0;
    bus.lim_open   = 1'b1;
    tick();
    repeat (8) tick();
    bus.lim_open = 1'b0;
    tick();
    bus.lim_closed = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.lim_open  = 1'b0;
    bus.lim_closed = 1'b1;
    bus.beam_n    = 1'b1;
    bus.fault_clr = 1'b0;
    #12;
    chk_cnt++;
    if (obs !== IdleV) $display("FAIL reset_values: got %b want %b", obs, IdleV);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if (obs !== IdleV) $display("FAIL idle_after_reset: got %b want %b", obs, IdleV);
    else pass_cnt++;
  endtask

  task automatic test_normal_entry();
    bus.entry_req = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== OpenEntry) $display("FAIL entry_grant: got %b want %b", obs, OpenEntry);
    else pass_cnt++;
    bus.entry_req  = 1'b0;
    bus.lim_closed = 1'b0;
    repeat (4) tick();
    bus.lim_open = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== HoldEntry) $display("FAIL entry_hold: got %b want %b", obs, HoldEntry);
    else pass_cnt++;
    repeat (7) tick();
    chk_cnt++;
    if (obs !== HoldEntry) $display("FAIL hold_7th_cycle: got %b want %b", obs, HoldEntry);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (obs !== CloseEntry) $display("FAIL hold_to_close: got %b want %b", obs, CloseEntry);
    else pass_cnt++;
    bus.lim_open = 1'b0;
    repeat (2) tick();
    bus.lim_closed = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== DoneV) $display("FAIL entry_done: got %b want %b", obs, DoneV);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (obs !== IdleV) $display("FAIL done_one_cycle: got %b want %b", obs, IdleV);
    else pass_cnt++;
  endtask

  task automatic test_tie();
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== TieFirst) $display("FAIL tie_first: got %b want %b", obs, TieFirst);
    else pass_cnt++;
    run_to_idle();
    chk_cnt++;
    if (obs !== DoneV) $display("FAIL tie_first_done: got %b want %b", obs, DoneV);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (obs !== TieSecond) $display("FAIL tie_second: got %b want %b", obs, TieSecond);
    else pass_cnt++;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.lim_closed = 1'b0;
    tick();
    chk_cnt++;
    if (obs !== TieSecond) $display("FAIL grant_kept_after_drop: got %b want %b", obs, TieSecond);
    else pass_cnt++;
    run_to_idle();
    chk_cnt++;
    if (obs !== DoneV) $display("FAIL tie_second_done: got %b want %b", obs, DoneV);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_lone_exit();
    bus.exit_req = 1'b1;
    tick();
    bus.exit_req   = 1'b0;
    bus.lim_closed = 1'b0;
    bus.lim_open   = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== HoldExit) $display("FAIL exit_hold: got %b want %b", obs, HoldExit);
    else pass_cnt++;
    repeat (8) tick();
    bus.lim_open   = 1'b0;
    bus.lim_closed = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_beam();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req  = 1'b0;
    bus.lim_closed = 1'b0;
    bus.lim_open   = 1'b1;
    tick();
    repeat (3) tick();
    bus.beam_n = 1'b0;
    repeat (3) tick();
    bus.beam_n = 1'b1;
    repeat (7) tick();
    chk_cnt++;
    if (obs !== HoldEntry) $display("FAIL hold_restart: got %b want %b", obs, HoldEntry);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (obs !== CloseEntry) $display("FAIL close_after_clear: got %b want %b", obs, CloseEntry);
    else pass_cnt++;
    bus.lim_open = 1'b0;
    tick();
    bus.beam_n     = 1'b0;
    bus.lim_closed = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== OpenEntry) $display("FAIL beam_reversal: got %b want %b", obs, OpenEntry);
    else pass_cnt++;
    bus.beam_n     = 1'b1;
    bus.lim_closed = 1'b0;
    bus.lim_open   = 1'b1;
    tick();
    repeat (8) tick();
    bus.lim_open = 1'b0;
    bus.lim_closed = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== DoneV) $display("FAIL beam_done: got %b want %b", obs, DoneV);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req  = 1'b0;
    bus.lim_closed = 1'b0;
    repeat (15) tick();
    chk_cnt++;
    if (obs !== OpenEntry) $display("FAIL opening_15: got %b want %b", obs, OpenEntry);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (obs !== FaultV) $display("FAIL move_timeout: got %b want %b", obs, FaultV);
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if (obs !== FaultV) $display("FAIL fault_held: got %b want %b", obs, FaultV);
    else pass_cnt++;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk_cnt++;
    if (obs !== IdleV) $display("FAIL fault_clear: got %b want %b", obs, IdleV);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (obs !== CloseNone) $display("FAIL homing: got %b want %b", obs, CloseNone);
    else pass_cnt++;
    bus.lim_closed = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== IdleV) $display("FAIL homing_no_done: got %b want %b", obs, IdleV);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req  = 1'b0;
    bus.lim_closed = 1'b0;
    bus.lim_open   = 1'b1;
    tick();
    repeat (8) tick();
    bus.lim_open = 1'b0;
    tick();
    bus.lim_open   = 1'b1;
    bus.lim_closed = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== FaultV) $display("FAIL limit_conflict: got %b want %b", obs, FaultV);
    else pass_cnt++;
    bus.lim_open  = 1'b0;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req  = 1'b0;
    bus.lim_closed = 1'b0;
    repeat (2) tick();
    chk_cnt++;
    if (obs !== OpenEntry) $display("FAIL pre_reset_opening: got %b want %b", obs, OpenEntry);
    else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (obs !== IdleV) $display("FAIL async_reset: got %b want %b", obs, IdleV);
    else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== CloseNone) $display("FAIL post_reset_homing: got %b want %b", obs, CloseNone);
    else pass_cnt++;
    bus.lim_closed = 1'b1;
    tick();
    chk_cnt++;
    if (obs !== IdleV) $display("FAIL post_reset_idle: got %b want %b", obs, IdleV);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_normal_entry();
    test_tie();
    test_lone_exit();
    test_beam();
    test_timeout();
    test_conflict();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
